// File: rtl/vxe_mem_hub_pkg.sv
// Shared memory-hub constants: response word layout and the skid buffer occupancy states.
// The request router uses the same field widths.
package vxe_mem_hub_pkg;

  localparam int CID_W        = 6;
  localparam int DATA_W       = 64;
  localparam int RSS_W        = CID_W + DATA_W;
  localparam int RSS_CID_MSB  = RSS_W - 1;
  localparam int RSS_CID_LSB  = DATA_W;
  localparam int RSS_DATA_MSB = DATA_W - 1;
  localparam int RSS_DATA_LSB = 0;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/vxe_mem_hub_skid2.sv
// Generic 2-entry show-ahead FIFO. The head drives dout and cnt reports occupancy.
// Storage is not reset; only occupancy and pointers are.
module vxe_mem_hub_skid2
  import vxe_mem_hub_pkg::*;
#(
  parameter int W = RSS_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   cnt
);

  skid_state_e  state_r;
  skid_state_e  state_nxt_s;
  logic [W-1:0] mem_r [2];
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic         push_s;
  logic         pop_s;
  logic         resync_s;

  assign push_s = push && ((state_r == SKID_EMPTY) || (state_r == SKID_ONE));
  assign pop_s  = pop  && ((state_r == SKID_ONE)   || (state_r == SKID_FULL));

  // Occupancy next state; an illegal encoding recovers to EMPTY and realigns the pointers
  always_comb begin
    state_nxt_s = state_r;
    resync_s    = 1'b0;
    case (state_r)
      SKID_EMPTY: begin
        if (push_s) state_nxt_s = SKID_ONE;
        else        state_nxt_s = SKID_EMPTY;
      end
      SKID_ONE: begin
        if (push_s && !pop_s)      state_nxt_s = SKID_FULL;
        else if (!push_s && pop_s) state_nxt_s = SKID_EMPTY;
        else                       state_nxt_s = SKID_ONE;
      end
      SKID_FULL: begin
        if (pop_s) state_nxt_s = SKID_ONE;
        else       state_nxt_s = SKID_FULL;
      end
      default: begin
        state_nxt_s = SKID_EMPTY;
        resync_s    = 1'b1;
      end
    endcase
  end

  // Occupancy state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= SKID_EMPTY;
    else     state_r <= state_nxt_s;
  end

  // Read and write pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
    end else if (resync_s) begin
      rd_ptr_r <= wr_ptr_r;
    end else begin
      if (push_s) wr_ptr_r <= ~wr_ptr_r;
      if (pop_s)  rd_ptr_r <= ~rd_ptr_r;
    end
  end

  // Data storage
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= din;
  end

  assign dout = mem_r[rd_ptr_r];
  assign cnt  = state_r;

endmodule

// File: rtl/vxe_mem_hub_cu_ds.sv
// CU downstream response merge. Responses from two master queues are round-robin
// arbitrated into a 2-entry skid buffer that feeds one CU sink.
module vxe_mem_hub_cu_ds #(
  parameter int CID_W  = vxe_mem_hub_pkg::CID_W,
  parameter int DATA_W = vxe_mem_hub_pkg::DATA_W,
  parameter int RSS_W  = CID_W + DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_m0_rss_vld,
  input  logic [RSS_W-1:0] i_m0_rss,
  output logic             o_m0_rss_rd,
  input  logic             i_m1_rss_vld,
  input  logic [RSS_W-1:0] i_m1_rss,
  output logic             o_m1_rss_rd,
  input  logic             i_rss_rdy,
  output logic [RSS_W-1:0] o_rss,
  output logic             o_rss_wr
);

  logic [1:0]       cnt_s;
  logic             accept_s;
  logic             grant_m1_s;
  logic             push_s;
  logic [RSS_W-1:0] push_data_s;
  logic             lg_r;

  // No pops while reset is held, even though the buffer already reads as empty
  assign accept_s    = !rst && (cnt_s != vxe_mem_hub_pkg::SKID_FULL);
  assign grant_m1_s  = i_m1_rss_vld && (!i_m0_rss_vld || !lg_r);
  assign o_m1_rss_rd = accept_s && grant_m1_s;
  assign o_m0_rss_rd = accept_s && i_m0_rss_vld && !grant_m1_s;
  assign push_s      = o_m0_rss_rd || o_m1_rss_rd;
  assign push_data_s = o_m1_rss_rd ? i_m1_rss : i_m0_rss;
  assign o_rss_wr    = (cnt_s != vxe_mem_hub_pkg::SKID_EMPTY) && i_rss_rdy;

  // Last-granted master; the reset value makes the first tie go to M0
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              lg_r <= 1'b1;
    else if (o_m1_rss_rd) lg_r <= 1'b1;
    else if (o_m0_rss_rd) lg_r <= 1'b0;
    else                  lg_r <= lg_r;
  end

  vxe_mem_hub_skid2 #(.W(RSS_W)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (push_s),
    .din  (push_data_s),
    .pop  (o_rss_wr),
    .dout (o_rss),
    .cnt  (cnt_s)
  );

endmodule

// File: tb/tb_vxe_mem_hub_cu_ds.sv
// Self-checking bench for vxe_mem_hub_cu_ds: a directed vector table, hand-written
// sequences and a randomized run, all checked against a queue-based reference model.
module tb_vxe_mem_hub_cu_ds;
  import vxe_mem_hub_pkg::*;

  localparam int W = RSS_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         m0_vld, m1_vld, m0_rd, m1_rd, rss_rdy, rss_wr;
  logic [W-1:0] m0_rss, m1_rss, rss;

  always #5 clk = ~clk;

  vxe_mem_hub_cu_ds dut (
    .clk          (clk),
    .rst          (rst),
    .i_m0_rss_vld (m0_vld),
    .i_m0_rss     (m0_rss),
    .o_m0_rss_rd  (m0_rd),
    .i_m1_rss_vld (m1_vld),
    .i_m1_rss     (m1_rss),
    .o_m1_rss_rd  (m1_rd),
    .i_rss_rdy    (rss_rdy),
    .o_rss        (rss),
    .o_rss_wr     (rss_wr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [5:0] cid, input logic [63:0] d);
    return {cid, d};
  endfunction

  function automatic logic [W-1:0] wa(input int i);
    return mk(6'd10, 64'h00000000000000A0 + 64'(i));
  endfunction

  function automatic logic [W-1:0] wb(input int i);
    return mk(6'd11, 64'h00000000000000B0 + 64'(i));
  endfunction

  // Reference model: source queues, FIFO contents and last-granted master
  logic [W-1:0] src0_q[$], src1_q[$], mdl_buf[$], out_log[$];
  int           out_cyc[$];
  bit           mdl_lg = 1'b1;
  int           cyc = 0;
  bit           sb_en = 1'b0;
  int           sb_seq[2];
  int           gen_seq[2];

  task automatic step(input bit rdy, input bit g0, input bit g1);
    bit           v0, v1, e_rd0, e_rd1, e_wr, pick_m1;
    logic [95:0]  junk;
    logic [W-1:0] e_rss;
    junk    = {$urandom(), $urandom(), $urandom()};
    v0      = g0 && (src0_q.size() > 0);
    v1      = g1 && (src1_q.size() > 0);
    m0_vld  = v0;
    m0_rss  = v0 ? src0_q[0] : junk[W-1:0];
    m1_vld  = v1;
    m1_rss  = v1 ? src1_q[0] : ~junk[W-1:0];
    rss_rdy = rdy;
    @(negedge clk);
    e_wr  = (mdl_buf.size() > 0) && rdy;
    e_rss = (mdl_buf.size() > 0) ? mdl_buf[0] : '0;
    pick_m1 = (v0 && v1) ? !mdl_lg : v1;
    e_rd0 = (mdl_buf.size() < 2) && (v0 || v1) && !pick_m1;
    e_rd1 = (mdl_buf.size() < 2) && (v0 || v1) && pick_m1;
    chk("m0_rd", m0_rd, e_rd0);
    chk("m1_rd", m1_rd, e_rd1);
    chk("rss_wr", rss_wr, e_wr);
    chk("wr_without_rdy", rss_wr & ~rss_rdy, 1'b0);
    if (e_wr) chk("rss_data", rss, e_rss);
    if (rss_wr) begin
      out_log.push_back(rss);
      out_cyc.push_back(cyc);
      if (sb_en) begin
        chk("sb_order", rss[31:0], sb_seq[rss[32]]);
        sb_seq[rss[32]]++;
      end
    end
    @(posedge clk);
    if (e_wr) void'(mdl_buf.pop_front());
    if (e_rd0) begin mdl_buf.push_back(src0_q.pop_front()); mdl_lg = 1'b0; end
    if (e_rd1) begin mdl_buf.push_back(src1_q.pop_front()); mdl_lg = 1'b1; end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0_vld = 1'b1; m1_vld = 1'b1; rss_rdy = 1'b1;
    #1;
    chk("rst_m0_rd", m0_rd, 1'b0);
    chk("rst_m1_rd", m1_rd, 1'b0);
    chk("rst_wr", rss_wr, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    mdl_buf.delete(); src0_q.delete(); src1_q.delete();
    mdl_lg = 1'b1;
  endtask

  typedef struct {
    logic v0; logic [W-1:0] d0; logic v1; logic [W-1:0] d1; logic rdy;
    logic e_rd0; logic e_rd1; logic e_wr; logic [W-1:0] e_rss;
  } vec_t;
  vec_t vt[13];

  initial begin
    logic [W-1:0] w5, first_exp, exp_seq[8];
    int base;
    w5 = mk(6'd5, 64'h1111111111111111);
    rst = 1'b1; m0_vld = 1'b0; m1_vld = 1'b0; m0_rss = '0; m1_rss = '0; rss_rdy = 1'b0;

    // From reset (lg=1): single-source pop, then a 5-cycle stall with both valid
    vt[0]  = '{1'b1, w5,    1'b0, '0,    1'b1, 1'b1, 1'b0, 1'b0, '0};
    vt[1]  = '{1'b0, '0,    1'b0, '0,    1'b1, 1'b0, 1'b0, 1'b1, w5};
    vt[2]  = '{1'b0, '0,    1'b0, '0,    1'b1, 1'b0, 1'b0, 1'b0, '0};
    vt[3]  = '{1'b1, wa(0), 1'b1, wb(0), 1'b0, 1'b0, 1'b1, 1'b0, '0};
    vt[4]  = '{1'b1, wa(0), 1'b1, wb(1), 1'b0, 1'b1, 1'b0, 1'b0, '0};
    vt[5]  = '{1'b1, wa(1), 1'b1, wb(1), 1'b0, 1'b0, 1'b0, 1'b0, '0};
    vt[6]  = '{1'b1, wa(1), 1'b1, wb(1), 1'b0, 1'b0, 1'b0, 1'b0, '0};
    vt[7]  = '{1'b1, wa(1), 1'b1, wb(1), 1'b0, 1'b0, 1'b0, 1'b0, '0};
    vt[8]  = '{1'b1, wa(1), 1'b1, wb(1), 1'b1, 1'b0, 1'b0, 1'b1, wb(0)};
    vt[9]  = '{1'b1, wa(1), 1'b1, wb(1), 1'b1, 1'b0, 1'b1, 1'b1, wa(0)};
    vt[10] = '{1'b1, wa(1), 1'b1, wb(2), 1'b1, 1'b1, 1'b0, 1'b1, wb(1)};
    vt[11] = '{1'b0, '0,    1'b0, '0,    1'b1, 1'b0, 1'b0, 1'b1, wa(1)};
    vt[12] = '{1'b0, '0,    1'b0, '0,    1'b1, 1'b0, 1'b0, 1'b0, '0};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      m0_vld = vt[i].v0; m0_rss = vt[i].d0;
      m1_vld = vt[i].v1; m1_rss = vt[i].d1;
      rss_rdy = vt[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_m0_rd", i), m0_rd, vt[i].e_rd0);
      chk($sformatf("vec%0d_m1_rd", i), m1_rd, vt[i].e_rd1);
      chk($sformatf("vec%0d_wr", i), rss_wr, vt[i].e_wr);
      if (vt[i].e_wr) chk($sformatf("vec%0d_rss", i), rss, vt[i].e_rss);
      @(posedge clk); #1;
    end

    // Both valid with 4 words each: strict alternation, no bubbles
    do_reset();
    for (int i = 0; i < 4; i++) begin
      src0_q.push_back(wa(i)); src1_q.push_back(wb(i));
      exp_seq[2*i] = wa(i); exp_seq[2*i+1] = wb(i);
    end
    base = out_log.size();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1);
    chk("alt_count", out_log.size() - base, 8);
    if (out_log.size() - base >= 8) begin
      for (int i = 0; i < 8; i++) chk($sformatf("alt_order%0d", i), out_log[base+i], exp_seq[i]);
      chk("alt_no_bubble", out_cyc[base+7] - out_cyc[base], 7);
    end

    // Tie after a solo M1 run goes to M0
    do_reset();
    for (int i = 0; i < 3; i++) src1_q.push_back(wb(i));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    src0_q.push_back(wa(7)); src1_q.push_back(wb(7));
    m0_vld = 1'b1; m0_rss = wa(7); m1_vld = 1'b1; m1_rss = wb(7); rss_rdy = 1'b1;
    #1;
    chk("tie_after_solo_m0", m0_rd, 1'b1);
    chk("tie_after_solo_m1", m1_rd, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);

    // Reset asserted mid-stream with the buffer full
    do_reset();
    for (int i = 0; i < 4; i++) begin src0_q.push_back(wa(i)); src1_q.push_back(wb(i)); end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
    rss_rdy = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("midrst_m0_rd", m0_rd, 1'b0);
    chk("midrst_m1_rd", m1_rd, 1'b0);
    chk("midrst_wr", rss_wr, 1'b0);
    @(posedge clk); #1;
    chk("midrst_hold_wr", rss_wr, 1'b0);
    rst = 1'b0;
    mdl_buf.delete(); mdl_lg = 1'b1;
    first_exp = src0_q[0];
    base = out_log.size();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);
    chk("midrst_out_count", out_log.size() - base, 3);
    if (out_log.size() > base) chk("midrst_first_word", out_log[base], first_exp);

    // Randomized run with a per-master sequence scoreboard
    do_reset();
    sb_en = 1'b1;
    sb_seq[0] = 0; sb_seq[1] = 0; gen_seq[0] = 0; gen_seq[1] = 0;
    for (int i = 0; i < 10000; i++) begin
      if (src0_q.size() < 3 && $urandom_range(0, 3) != 0) begin
        src0_q.push_back(mk(6'($urandom()), {32'd0, 32'(gen_seq[0])}));
        gen_seq[0]++;
      end
      if (src1_q.size() < 3 && $urandom_range(0, 3) != 0) begin
        src1_q.push_back(mk(6'($urandom()), {32'd1, 32'(gen_seq[1])}));
        gen_seq[1]++;
      end
      step($urandom_range(0, 9) < 7, $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0);
    end
    for (int i = 0; i < 200; i++) begin
      if (src0_q.size() == 0 && src1_q.size() == 0 && mdl_buf.size() == 0) break;
      step(1'b1, 1'b1, 1'b1);
    end
    step(1'b1, 1'b1, 1'b1);
    chk("rand_m0_delivered", sb_seq[0], gen_seq[0]);
    chk("rand_m1_delivered", sb_seq[1], gen_seq[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vxe_mem_hub_cu_ds.md
Name: vxe_mem_hub_cu_ds

Overview:
- CU downstream response path: merges read responses returned by Master 0 and Master 1 into a single response stream to one CU.
- Counterpart of the CU upstream request router. Requests go out to whichever master is selected, so responses for one CU can come back from either master, interleaved.
- Round-robin arbitration between the two master response queues, with a 2-entry output skid buffer to sustain 1 response/cycle.

Parameters:
- CID_W, 6, client ID width carried in the response.
- DATA_W, 64, response data width.
- RSS_W, CID_W+DATA_W (70), response word width: { CID, Data }.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- i_m0_rss_vld  in  1  Master 0 response queue not empty.
- i_m0_rss  in  RSS_W  Master 0 response queue head, show-ahead.
- o_m0_rss_rd  out  1  pop Master 0 response queue.
- i_m1_rss_vld  in  1  Master 1 response queue not empty.
- i_m1_rss  in  RSS_W  Master 1 response queue head, show-ahead.
- o_m1_rss_rd  out  1  pop Master 1 response queue.
- i_rss_rdy  in  1  CU response sink not full.
- o_rss  out  RSS_W  response to CU.
- o_rss_wr  out  1  push to CU response sink.

Interface decision: one clock; reset is asynchronous and active-high.

Behaviour:
- Source handshake: i_mX_rss is valid whenever i_mX_rss_vld=1. Asserting o_mX_rss_rd in that cycle consumes the word; the next head appears the following cycle.
- Sink handshake: a word transfers in any cycle with o_rss_wr=1. o_rss_wr is never asserted while i_rss_rdy=0.
- Skid buffer: 2 entries, count cnt in {0,1,2}, FIFO order. Head drives o_rss.
- o_rss_wr = (cnt!=0) && i_rss_rdy. This path is combinational from i_rss_rdy.
- Accept condition: accept = (cnt<2). No same-cycle bypass at cnt==2.
- Arbitration: a register lg (last granted, 0=M0, 1=M1).
  - Only one source valid: grant that source.
  - Both valid: grant !lg.
  - o_mX_rss_rd = accept && grant==X && i_mX_rss_vld. At most one rd per cycle.
  - lg updates to X only on an actual pop from X.
- Count update: cnt_next = cnt + pop - o_rss_wr. Simultaneous push and drain at cnt==1 holds cnt at 1 with a new head.
- Latency: a word popped in cycle N appears on o_rss in N+1. o_rss_wr in N+1 if i_rss_rdy=1.
- Throughput: 1 word/cycle sustained when i_rss_rdy stays high. Strict alternation M0/M1 when both are continuously valid.
- Stall: i_rss_rdy=0 fills the buffer to cnt=2, after which both rd outputs are 0. Order is preserved on release.
- No reordering within a master. Cross-master order is defined solely by arbitration order.
- Reset, async, any time: cnt=0, lg=1 (first tie goes to M0), o_rss_wr=0, o_m0_rss_rd=0, o_m1_rss_rd=0. Buffered words are dropped. Data storage is not reset; o_rss is don't-care while cnt=0.
- Counter FSM states: EMPTY (cnt=0), ONE (cnt=1), FULL (cnt=2). Illegal encodings go to EMPTY.

Decomposition:
- Shared package vxe_mem_hub_pkg: CID_W, DATA_W, RSS_W, and the response field offsets (CID at [RSS_W-1:DATA_W]). These are shared with the upstream router's request format constants.
- Sub-module vxe_mem_hub_skid2: a generic 2-entry show-ahead buffer with push/pop/cnt. The arbiter stays in the top module.

Test Plan:
- Single source: M0 supplies CID=5, data 0x1111..11 with i_rss_rdy=1 → o_m0_rss_rd in cycle 0; o_rss={5,0x11..11} with o_rss_wr=1 in cycle 1; M1 rd never asserted.
- Both valid, 4 words each (M0 tags 0xA0..A3, M1 tags 0xB0..B3) → output order A0,B0,A1,B1,A2,B2,A3,B3 with no bubbles.
- Backpressure: i_rss_rdy=0 for 5 cycles while both sources are valid → exactly 2 pops, then rd=0. After release, the 2 buffered words drain first and streaming resumes at 1/cycle.
- Tie after a solo run: 3 pops from M1 only, then both become valid → next grant is M0.
- Reset mid-stream at cnt=2 → next cycle o_rss_wr=0 and both rd outputs 0. After deassert, the first tie goes to M0 and no stale word is emitted.
- Random stall/valid, 10k cycles → scoreboard shows per-master order preserved, no drops or duplicates, o_rss_wr never asserted with i_rss_rdy=0.
